image_ram_wrapper: RTL and testbench



---
 rtl/image_ram_wrapper.sv | 104 ++++++++++
 tb/tb_image_ram_wrapper.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/image_ram_wrapper.sv
// -----------------------------------------------------------------------------
// image_ram_wrapper
//
// Simple dual-port image buffer for the LeNet accelerator. Port A only writes
// (pixel loading); Port B only reads (feeds the convolution datapath). Both
// ports share one rising-edge clock. The read is registered with one cycle of
// latency. When both ports hit the same address on the same edge, the read
// returns the old word and the new word is stored (read-first).
//
// The storage comes up holding a deterministic 28x28 test image:
//   mem[i] = (i mod 28) + (i div 28) for i < 784, and 0 above that.
// That image is part of the storage's power-up value. Reset never touches the
// array, so the preset image and any later writes survive a reset.
//
// Ports:
//   clk    in   1           single clock, rising edge, both ports
//   rst_n  in   1           asynchronous active-low reset (clears doutb only)
//   ena    in   1           Port A enable
//   wea    in   1           Port A write enable, effective only with ena=1
//   addra  in   ADDR_WIDTH  Port A write address
//   dina   in   DATA_WIDTH  Port A write data
//   enb    in   1           Port B read enable
//   addrb  in   ADDR_WIDTH  Port B read address
//   doutb  out  DATA_WIDTH  Port B registered read data
//
// Port semantics: there is no handshake. A write happens on every rising edge
// where rst_n=1, ena=1 and wea=1. A read is captured on every rising edge
// where rst_n=1 and enb=1. With enb=0, doutb keeps its last value.
// -----------------------------------------------------------------------------
module image_ram_wrapper #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int IMG_SIDE   = 28;
  localparam int IMG_PIXELS = IMG_SIDE * IMG_SIDE;

  typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_t;

  // Builds the power-up image: row + col inside the 28x28 region, zero above.
  // Pixels that fall beyond the array (only possible with a small ADDR_WIDTH)
  // are skipped.
  function automatic mem_t init_image();
    mem_t img;
    img = '0;
    for (int i = 0; i < IMG_PIXELS; i++) begin
      if (i < DEPTH) begin
        img[ADDR_WIDTH'(i)] = DATA_WIDTH'((i % IMG_SIDE) + (i / IMG_SIDE));
      end
    end
    return img;
  endfunction

  // The storage gets its image from its declared initial value rather than
  // from reset. That keeps reset off the RAM array, so the array can map onto
  // block RAM with the image as its configuration contents.
  mem_t mem_q = init_image();

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] doutb_q;
  logic [DATA_WIDTH-1:0] doutb_d;

  // Writes are blocked while reset is held low.
  assign wr_en = rst_n & ena & wea;

  // Write port. It has no reset, so the contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addra] <= dina;
    end
  end

  // The next read value samples the array as it stands before this edge's
  // write commits. That is what gives read-first behaviour on a collision.
  always_comb begin
    doutb_d = doutb_q;
    if (enb) begin
      doutb_d = mem_q[addrb];
    end
  end

  // Read register: async clear, otherwise holds unless a read is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doutb_q <= '0;
    end else begin
      doutb_q <= doutb_d;
    end
  end

  assign doutb = doutb_q;

endmodule

// File: tb/tb_image_ram_wrapper.sv
module tb_image_ram_wrapper;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ena = 1'b0;
  logic          wea = 1'b0;
  logic [AW-1:0] addra = '0;
  logic [DW-1:0] dina = '0;
  logic          enb = 1'b0;
  logic [AW-1:0] addrb = '0;
  logic [DW-1:0] doutb;

  always #5 clk = ~clk;

  image_ram_wrapper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .enb   (enb),
    .addrb (addrb),
    .doutb (doutb)
  );

  // ---------------- reference model / scoreboard ----------------
  // The model is a plain array that starts with the specified image. Each
  // edge's read result goes onto exp_q, and the checker pops it.
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_dout;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) begin
      int row, col;
      row = i / 28;
      col = i % 28;
      model[i] = (i < 784) ? DW'(row + col) : '0;
    end
    last_dout = '0;
  endtask

  // ---------------- driver ----------------
  // This task drives one clock's worth of inputs and waits for the edge. It
  // then updates the model: reads see the pre-edge contents, the write lands
  // afterwards, and nothing changes while reset is low. The expected output
  // is pushed onto exp_q.
  task automatic step(input logic e_a, input logic w_a, input logic [AW-1:0] a_a,
                      input logic [DW-1:0] d_a, input logic e_b, input logic [AW-1:0] a_b);
    ena = e_a; wea = w_a; addra = a_a; dina = d_a; enb = e_b; addrb = a_b;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (e_b) last_dout = model[a_b];
      if (e_a && w_a) model[a_a] = d_a;
    end else begin
      last_dout = '0;
    end
    exp_q.push_back(last_dout);
  endtask

  task automatic read(input logic [AW-1:0] a);
    step(1'b0, 1'b0, '0, '0, 1'b1, a);
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b1, 1'b1, a, d, 1'b0, '0);
  endtask

  task automatic check_sb(input string tag);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, doutb, ~doutb);
    end else begin
      e = exp_q.pop_front();
      check(tag, doutb, e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_init();

    // Assert reset without a clock edge, then hold it for 200 cycles.
    #2 rst_n = 1'b0;
    #1 check("reset_async", doutb, 8'h00);
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, AW'($urandom), DW'($urandom),
           1'b1, AW'($urandom));
      check_sb("reset_hold");
    end
    // The writes attempted during reset must not have landed. The model
    // already ignored them, and the image spot-checks below confirm this.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, AW'($urandom));
      check_sb("release_enb0");
    end

    // Sweep all addresses twice and spot-check a few fixed image values.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < DEPTH; i++) begin
        read(AW'(i));
        check_sb("sweep");
        if (i == 0)   check("img_addr0",   doutb, 8'h00);
        if (i == 1)   check("img_addr1",   doutb, 8'h01);
        if (i == 27)  check("img_addr27",  doutb, 8'h1B);
        if (i == 28)  check("img_addr28",  doutb, 8'h01);
        if (i == 783) check("img_addr783", doutb, 8'h36);
        if (i == 784) check("img_addr784", doutb, 8'h00);
        if (i == 1023) check("img_addr1023", doutb, 8'h00);
      end
    end

    // Directed writes, then read them back.
    write(10'd0, 8'hAA);    check_sb("wr0");
    write(10'd1, 8'hBB);    check_sb("wr1");
    write(10'd784, 8'hCC);  check_sb("wr784");
    write(10'd1023, 8'hDD); check_sb("wr1023");
    read(10'd0);    check("rd0_AA",    doutb, 8'hAA); void'(exp_q.pop_front());
    read(10'd1);    check("rd1_BB",    doutb, 8'hBB); void'(exp_q.pop_front());
    read(10'd784);  check("rd784_CC",  doutb, 8'hCC); void'(exp_q.pop_front());
    read(10'd1023); check("rd1023_DD", doutb, 8'hDD); void'(exp_q.pop_front());
    read(10'd2);    check("rd2_untouched",   doutb, 8'h02); void'(exp_q.pop_front());
    read(10'd785);  check("rd785_untouched", doutb, 8'h00); void'(exp_q.pop_front());

    // Same-edge collision: the read returns the old word.
    step(1'b1, 1'b1, 10'd5, 8'h77, 1'b1, 10'd5);
    check("collision_old", doutb, 8'h05); void'(exp_q.pop_front());
    read(10'd5); check("collision_new", doutb, 8'h77); void'(exp_q.pop_front());

    // With enb=0, doutb holds while addrb moves. ena=1 with wea=0 must not write.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 10'd6, 8'hEE, 1'b0, AW'($urandom));
      check("hold_enb0", doutb, 8'h77); void'(exp_q.pop_front());
    end
    read(10'd6); check("no_write_wea0", doutb, 8'h06); void'(exp_q.pop_front());

    // Randomized traffic. Addresses are often drawn from a small window so
    // that collisions happen.
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] aa, ab;
      if ($urandom_range(0, 3) == 0) begin
        aa = AW'($urandom_range(0, 7));
        ab = AW'($urandom_range(0, 7));
      end else begin
        aa = AW'($urandom);
        ab = AW'($urandom);
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), aa, DW'($urandom),
           1'($urandom_range(0, 1)), ab);
      check_sb("random");
    end

    // Reset in the middle of a sweep: doutb clears at once, with no clock edge.
    for (int i = 0; i < 20; i++) begin
      read(AW'(i + 100));
      check_sb("presweep");
    end
    write(10'd0, 8'hAA); check_sb("rewr0");
    #2 rst_n = 1'b0;
    #1 check("midsweep_async_clear", doutb, 8'h00);
    last_dout = '0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 10'd0, 8'h11, 1'b1, AW'(i));
      check_sb("midsweep_reset_hold");
    end
    rst_n = 1'b1;
    read(10'd0); check("survive_reset_AA", doutb, 8'hAA); void'(exp_q.pop_front());
    for (int i = 0; i < 64; i++) begin
      read(AW'($urandom));
      check_sb("post_reset");
    end

    check("sb_drained", 8'(exp_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
